drop_controller: RTL and testbench

- Writer side of the board column-update interface.
- Accepts a player's column choice and reads the current column from the board column memory.
- Stacks one piece on top of that column and issues the column write (address, onoff_write, player_write, go) to the board logic unit and back into the memory.
- Rejects illegal moves (bad column, full column, corrupted column, board full); tracks whose turn it is and how many moves have been made.

---
 rtl/drop_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_drop_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drop_controller.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// drop_controller
//
// Writer side of the board column-update interface. A player's column choice
// is checked, the current column is read from the board column memory, one
// piece is stacked on top of it and the updated column is written back to
// the memory and the board logic unit. Illegal moves are rejected with a
// one-cycle move_err pulse. The block also tracks whose turn it is and how
// many moves have been accepted.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   drop_req     one-cycle drop request, sampled only while idle
//   drop_col     requested column (0..COLS-1), sampled with drop_req
//   busy         high whenever a request is being processed
//   mem_rd_en    board memory read strobe (one cycle)
//   mem_addr     board memory read column
//   onoff_rd     occupancy column, valid one cycle after mem_rd_en
//   player_rd    owner column, valid one cycle after mem_rd_en
//   mem_wr_en    board memory write strobe (same as go)
//   address      column being written
//   onoff_write  new occupancy column
//   player_write new owner column
//   go           one-cycle write strobe to the logic unit
//   player_turn  player to move next
//   move_ok      one-cycle pulse on an accepted move, coincident with go
//   move_err     one-cycle pulse on a rejected request
//   move_count   accepted moves, saturating at ROWS*COLS
//   board_full   high when move_count reaches ROWS*COLS
//
// Column encoding: onoff is thermometer coded from bit 0 (bottom); a player
// bit of 1 means player 1, unoccupied player bits are 0.
// ---------------------------------------------------------------------------
module drop_controller #(
    parameter int   ROWS         = 6,
    parameter int   COLS         = 7,
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       drop_req,
    input  logic [2:0] drop_col,
    output logic       busy,
    output logic       mem_rd_en,
    output logic [2:0] mem_addr,
    input  logic [5:0] onoff_rd,
    input  logic [5:0] player_rd,
    output logic       mem_wr_en,
    output logic [2:0] address,
    output logic [5:0] onoff_write,
    output logic [5:0] player_write,
    output logic       go,
    output logic       player_turn,
    output logic       move_ok,
    output logic       move_err,
    output logic [5:0] move_count,
    output logic       board_full
);

    localparam logic [5:0] MAX_MOVES = 6'(ROWS * COLS);
    localparam logic [2:0] MAX_COL   = 3'(COLS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_EVAL  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // A legal column is 0..01..1: adding one to it leaves no overlapping bits.
    function automatic logic is_thermo(input logic [5:0] v);
        logic [6:0] ext;
        logic [6:0] inc;
        ext = {1'b0, v};
        inc = ext + 7'd1;
        return ((ext & inc) == 7'd0);
    endfunction

    // Number of occupied cells, i.e. the row index of the next free cell.
    function automatic logic [2:0] ones_count(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Owner column with the cell at row h assigned to player who.
    function automatic logic [5:0] set_owner(input logic [5:0] p,
                                             input logic [2:0] h,
                                             input logic       who);
        logic [5:0] r;
        r = p;
        for (int i = 0; i < 6; i++) begin
            if (h == 3'(i)) begin
                r[i] = who;
            end else begin
                r[i] = p[i];
            end
        end
        return r;
    endfunction

    logic [2:0] state_r, state_s;
    logic [2:0] col_r, col_s;
    logic       turn_r, turn_s;
    logic       busy_r, busy_s;
    logic       mem_rd_en_r, mem_rd_en_s;
    logic [2:0] mem_addr_r, mem_addr_s;
    logic       go_r, go_s;
    logic [2:0] address_r, address_s;
    logic [5:0] onoff_write_r, onoff_write_s;
    logic [5:0] player_write_r, player_write_s;
    logic       player_turn_r, player_turn_s;
    logic       move_ok_r, move_ok_s;
    logic       move_err_r, move_err_s;
    logic [5:0] move_count_r, move_count_s;
    logic       board_full_s;

    assign board_full_s = (move_count_r == MAX_MOVES);

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_s        = state_r;
        col_s          = col_r;
        turn_s         = turn_r;
        mem_addr_s     = mem_addr_r;
        address_s      = address_r;
        onoff_write_s  = onoff_write_r;
        player_write_s = player_write_r;
        player_turn_s  = player_turn_r;
        move_count_s   = move_count_r;
        mem_rd_en_s    = 1'b0;
        go_s           = 1'b0;
        move_ok_s      = 1'b0;
        move_err_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (drop_req) begin
                    col_s  = drop_col;
                    turn_s = player_turn_r;
                    if ((drop_col > MAX_COL) || board_full_s) begin
                        state_s    = ST_ERR;
                        move_err_s = 1'b1;
                    end else begin
                        state_s     = ST_READ;
                        mem_rd_en_s = 1'b1;
                        mem_addr_s  = drop_col;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                // Memory returns the column during the following cycle.
                state_s = ST_EVAL;
            end
            ST_EVAL: begin
                if (onoff_rd[5] || !is_thermo(onoff_rd)) begin
                    state_s    = ST_ERR;
                    move_err_s = 1'b1;
                end else begin
                    state_s        = ST_WRITE;
                    go_s           = 1'b1;
                    move_ok_s      = 1'b1;
                    address_s      = col_r;
                    onoff_write_s  = {onoff_rd[4:0], 1'b1};
                    player_write_s = set_owner(player_rd, ones_count(onoff_rd), turn_r);
                    player_turn_s  = ~player_turn_r;
                    if (move_count_r < MAX_MOVES) begin
                        move_count_s = move_count_r + 6'd1;
                    end else begin
                        move_count_s = move_count_r;
                    end
                end
            end
            ST_WRITE: begin
                state_s = ST_IDLE;
            end
            ST_ERR: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            col_r          <= 3'd0;
            turn_r         <= 1'b0;
            busy_r         <= 1'b0;
            mem_rd_en_r    <= 1'b0;
            mem_addr_r     <= 3'd0;
            go_r           <= 1'b0;
            address_r      <= 3'd0;
            onoff_write_r  <= 6'd0;
            player_write_r <= 6'd0;
            player_turn_r  <= FIRST_PLAYER;
            move_ok_r      <= 1'b0;
            move_err_r     <= 1'b0;
            move_count_r   <= 6'd0;
        end else begin
            state_r        <= state_s;
            col_r          <= col_s;
            turn_r         <= turn_s;
            busy_r         <= busy_s;
            mem_rd_en_r    <= mem_rd_en_s;
            mem_addr_r     <= mem_addr_s;
            go_r           <= go_s;
            address_r      <= address_s;
            onoff_write_r  <= onoff_write_s;
            player_write_r <= player_write_s;
            player_turn_r  <= player_turn_s;
            move_ok_r      <= move_ok_s;
            move_err_r     <= move_err_s;
            move_count_r   <= move_count_s;
        end
    end

    assign busy         = busy_r;
    assign mem_rd_en    = mem_rd_en_r;
    assign mem_addr     = mem_addr_r;
    assign go           = go_r;
    assign mem_wr_en    = go_r;
    assign address      = address_r;
    assign onoff_write  = onoff_write_r;
    assign player_write = player_write_r;
    assign player_turn  = player_turn_r;
    assign move_ok      = move_ok_r;
    assign move_err     = move_err_r;
    assign move_count   = move_count_r;
    assign board_full   = board_full_s;

endmodule

// File: tb/tb_drop_controller.sv
`timescale 1ns/1ps
module tb_drop_controller;

    logic       clk;
    logic       reset;
    logic       drop_req;
    logic [2:0] drop_col;
    logic       busy;
    logic       mem_rd_en;
    logic [2:0] mem_addr;
    logic [5:0] onoff_rd;
    logic [5:0] player_rd;
    logic       mem_wr_en;
    logic [2:0] address;
    logic [5:0] onoff_write;
    logic [5:0] player_write;
    logic       go;
    logic       player_turn;
    logic       move_ok;
    logic       move_err;
    logic [5:0] move_count;
    logic       board_full;

    int n_checks = 0;
    int n_fail   = 0;

    // board memory model with a backdoor loader
    logic [5:0] mem_onoff  [0:7];
    logic [5:0] mem_player [0:7];
    logic       bd_we;
    logic [2:0] bd_col;
    logic [5:0] bd_onoff;
    logic [5:0] bd_player;

    drop_controller #(.ROWS(6), .COLS(7), .FIRST_PLAYER(1'b0)) dut (
        .clk(clk), .reset(reset), .drop_req(drop_req), .drop_col(drop_col),
        .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .onoff_rd(onoff_rd), .player_rd(player_rd), .mem_wr_en(mem_wr_en),
        .address(address), .onoff_write(onoff_write), .player_write(player_write),
        .go(go), .player_turn(player_turn), .move_ok(move_ok), .move_err(move_err),
        .move_count(move_count), .board_full(board_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) begin
            mem_onoff[bd_col]  <= bd_onoff;
            mem_player[bd_col] <= bd_player;
        end else if (mem_wr_en) begin
            mem_onoff[address]  <= onoff_write;
            mem_player[address] <= player_write;
        end
        if (mem_rd_en) begin
            onoff_rd  <= mem_onoff[mem_addr];
            player_rd <= mem_player[mem_addr];
        end
    end

    task automatic bd_write(input logic [2:0] c, input logic [5:0] o, input logic [5:0] p);
        bd_we = 1'b1; bd_col = c; bd_onoff = o; bd_player = p;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue a request (called at a negedge) and observe ncyc following negedges.
    // Cycle k=1 is the first sample after the edge that takes the request.
    task automatic drop(input logic [2:0] col, input int hold, input int ncyc,
                        output int go_cyc, output int err_cyc, output int rd_cyc,
                        output int go_cnt, output int rd_cnt,
                        output logic [2:0] ad, output logic [5:0] ow,
                        output logic [5:0] pw, output logic ok, output logic busy_end);
        go_cyc = -1; err_cyc = -1; rd_cyc = -1; go_cnt = 0; rd_cnt = 0;
        ad = 3'd0; ow = 6'd0; pw = 6'd0; ok = 1'b0; busy_end = 1'b1;
        drop_col = col;
        drop_req = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k > hold) drop_req = 1'b0;
            if (go) begin
                go_cnt++;
                if (go_cyc < 0) begin
                    go_cyc = k; ad = address; ow = onoff_write; pw = player_write; ok = move_ok;
                end
            end
            if (move_err && err_cyc < 0) err_cyc = k;
            if (mem_rd_en) begin
                rd_cnt++;
                if (rd_cyc < 0) rd_cyc = k;
            end
            busy_end = busy;
        end
        drop_req = 1'b0;
    endtask

    int gc, ec, rc, gn, rn;
    logic [2:0] ad;
    logic [5:0] ow, pw;
    logic ok, be;

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 8; c++) bd_write(3'(c), 6'd0, 6'd0);
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (go !== 1'b0 || mem_wr_en !== 1'b0 || move_ok !== 1'b0 || move_err !== 1'b0 || mem_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: go=%b wr=%b ok=%b err=%b rd=%b expected all 0", go, mem_wr_en, move_ok, move_err, mem_rd_en); end
        n_checks++; if ({address, mem_addr, onoff_write, player_write} !== 18'd0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {address, mem_addr, onoff_write, player_write}); end
        n_checks++; if (move_count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", move_count); end
        n_checks++; if (player_turn !== 1'b0) begin n_fail++; $display("FAIL reset_turn: got %b expected 0", player_turn); end
        n_checks++; if (board_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", board_full); end
    endtask

    task automatic test_first_drop();
        drop(3'd3, 0, 6, gc, ec, rc, gn, rn, ad, ow, pw, ok, be);
        n_checks++; if (rc !== 1 || rn !== 1) begin n_fail++; $display("FAIL first_read: got cyc %0d cnt %0d expected 1 1", rc, rn); end
        n_checks++; if (gc !== 3 || gn !== 1) begin n_fail++; $display("FAIL first_go: got cyc %0d cnt %0d expected 3 1", gc, gn); end
        n_checks++; if (ad !== 3'd3) begin n_fail++; $display("FAIL first_addr: got %0d expected 3", ad); end
        n_checks++; if (ow !== 6'b000001) begin n_fail++; $display("FAIL first_onoff: got %b expected 000001", ow); end
        n_checks++; if (pw !== 6'b000000) begin n_fail++; $display("FAIL first_player: got %b expected 000000", pw); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL first_move_ok: got %b expected 1", ok); end
        n_checks++; if (ec !== -1) begin n_fail++; $display("FAIL first_no_err: got cyc %0d expected -1", ec); end
        n_checks++; if (player_turn !== 1'b1) begin n_fail++; $display("FAIL first_turn: got %b expected 1", player_turn); end
        n_checks++; if (move_count !== 6'd1) begin n_fail++; $display("FAIL first_count: got %0d expected 1", move_count); end
        n_checks++; if (be !== 1'b0) begin n_fail++; $display("FAIL first_busy_end: got %b expected 0", be); end
    endtask

    task automatic test_second_drop();
        drop(3'd3, 0, 6, gc, ec, rc, gn, rn, ad, ow, pw, ok, be);
        n_checks++; if (gc !== 3) begin n_fail++; $display("FAIL second_go: got cyc %0d expected 3", gc); end
        n_checks++; if (ow !== 6'b000011) begin n_fail++; $display("FAIL second_onoff: got %b expected 000011", ow); end
        n_checks++; if (pw !== 6'b000010) begin n_fail++; $display("FAIL second_player: got %b expected 000010", pw); end
        n_checks++; if (player_turn !== 1'b0) begin n_fail++; $display("FAIL second_turn: got %b expected 0", player_turn); end
        n_checks++; if (move_count !== 6'd2) begin n_fail++; $display("FAIL second_count: got %0d expected 2", move_count); end
    endtask

    task automatic test_bad_col();
        drop(3'd7, 0, 6, gc, ec, rc, gn, rn, ad, ow, pw, ok, be);
        n_checks++; if (ec !== 1) begin n_fail++; $display("FAIL badcol_err: got cyc %0d expected 1", ec); end
        n_checks++; if (rn !== 0 || gn !== 0) begin n_fail++; $display("FAIL badcol_no_access: got rd %0d go %0d expected 0 0", rn, gn); end
        n_checks++; if (player_turn !== 1'b0 || move_count !== 6'd2) begin
            n_fail++; $display("FAIL badcol_state: got turn %b count %0d expected 0 2", player_turn, move_count); end
    endtask

    task automatic test_full_corrupt();
        bd_write(3'd5, 6'b111111, 6'b101010);
        bd_write(3'd6, 6'b000101, 6'b000100);
        drop(3'd5, 0, 6, gc, ec, rc, gn, rn, ad, ow, pw, ok, be);
        n_checks++; if (ec !== 3 || gn !== 0) begin n_fail++; $display("FAIL full_err: got err %0d go %0d expected 3 0", ec, gn); end
        n_checks++; if (rn !== 1) begin n_fail++; $display("FAIL full_read: got %0d expected 1", rn); end
        drop(3'd6, 0, 6, gc, ec, rc, gn, rn, ad, ow, pw, ok, be);
        n_checks++; if (ec !== 3 || gn !== 0) begin n_fail++; $display("FAIL corrupt_err: got err %0d go %0d expected 3 0", ec, gn); end
        n_checks++; if (player_turn !== 1'b0 || move_count !== 6'd2) begin
            n_fail++; $display("FAIL corrupt_state: got turn %b count %0d expected 0 2", player_turn, move_count); end
        n_checks++; if (address !== 3'd3 || onoff_write !== 6'b000011 || player_write !== 6'b000010) begin
            n_fail++; $display("FAIL write_hold: got %0d %b %b expected 3 000011 000010", address, onoff_write, player_write); end
        n_checks++; if (mem_addr !== 3'd6) begin n_fail++; $display("FAIL mem_addr_hold: got %0d expected 6", mem_addr); end
    endtask

    task automatic test_back_to_back();
        drop(3'd0, 2, 4, gc, ec, rc, gn, rn, ad, ow, pw, ok, be);
        n_checks++; if (gn !== 1 || gc !== 3) begin n_fail++; $display("FAIL busy_ignore_go: got cnt %0d cyc %0d expected 1 3", gn, gc); end
        n_checks++; if (rn !== 1) begin n_fail++; $display("FAIL busy_ignore_read: got %0d expected 1", rn); end
        n_checks++; if (be !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_idle: got %b expected 0", be); end
        drop(3'd0, 0, 6, gc, ec, rc, gn, rn, ad, ow, pw, ok, be);
        n_checks++; if (gc !== 3 || ad !== 3'd0) begin n_fail++; $display("FAIL b2b_go: got cyc %0d addr %0d expected 3 0", gc, ad); end
        n_checks++; if (ow !== 6'b000011 || pw !== 6'b000010) begin n_fail++; $display("FAIL b2b_data: got %b %b expected 000011 000010", ow, pw); end
        n_checks++; if (move_count !== 6'd4 || player_turn !== 1'b0) begin
            n_fail++; $display("FAIL b2b_state: got count %0d turn %b expected 4 0", move_count, player_turn); end
    endtask

    task automatic test_reset_mid();
        int g;
        g = 0;
        drop_col = 3'd1;
        drop_req = 1'b1;
        @(negedge clk);
        drop_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0 || go !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got busy %b go %b expected 0 0", busy, go); end
        n_checks++; if (move_count !== 6'd0 || player_turn !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state: got count %0d turn %b expected 0 0", move_count, player_turn); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (go) g++;
        end
        n_checks++; if (g !== 0) begin n_fail++; $display("FAIL midreset_no_go: got %0d expected 0", g); end
    endtask

    task automatic test_board_full();
        int bad;
        logic [6:0] t;
        logic [5:0] exp_ow;
        bad = 0;
        for (int c = 0; c < 7; c++) bd_write(3'(c), 6'd0, 6'd0);
        for (int i = 0; i < 42; i++) begin
            drop(3'(i / 6), 0, 4, gc, ec, rc, gn, rn, ad, ow, pw, ok, be);
            t = (7'd1 << ((i % 6) + 1)) - 7'd1;
            exp_ow = t[5:0];
            n_checks++;
            if (gc !== 3 || ow !== exp_ow || pw !== (exp_ow & 6'b101010) || ad !== 3'(i / 6)) begin
                n_fail++; bad++;
                if (bad < 4) $display("FAIL fill_move_%0d: got go %0d addr %0d %b %b expected 3 %0d %b %b",
                                      i, gc, ad, ow, pw, i / 6, exp_ow, exp_ow & 6'b101010);
            end
        end
        n_checks++; if (move_count !== 6'd42 || board_full !== 1'b1) begin
            n_fail++; $display("FAIL full_flag: got count %0d full %b expected 42 1", move_count, board_full); end
        drop(3'd0, 0, 6, gc, ec, rc, gn, rn, ad, ow, pw, ok, be);
        n_checks++; if (ec !== 1 || rn !== 0 || gn !== 0) begin
            n_fail++; $display("FAIL full_reject: got err %0d rd %0d go %0d expected 1 0 0", ec, rn, gn); end
        n_checks++; if (move_count !== 6'd42) begin n_fail++; $display("FAIL full_count_hold: got %0d expected 42", move_count); end
    endtask

    initial begin
        reset = 1'b1; drop_req = 1'b0; drop_col = 3'd0;
        bd_we = 1'b0; bd_col = 3'd0; bd_onoff = 6'd0; bd_player = 6'd0;
        @(negedge clk);
        test_reset();
        test_first_drop();
        test_second_drop();
        test_bad_col();
        test_full_corrupt();
        test_back_to_back();
        test_reset_mid();
        test_board_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
